// File: rtl/axis_tx_protocol_corrector.sv
// AXI-Stream tx framing corrector.
// Passes beats through with zero latency and closes every packet with a tlast:
// oversize packets are truncated, stalled or force-ended packets get an
// injected zero-keep terminator, and the untransmitted remainder is drained.
module axis_tx_protocol_corrector #(
    parameter int unsigned AXIS_BUS_WIDTH  = 64,
    parameter int unsigned AXIS_ID_WIDTH   = 4,
    parameter int unsigned AXIS_DEST_WIDTH = 4,
    parameter int unsigned MAX_PKT_BEATS   = 192,
    parameter int unsigned TIMEOUT_CYCLES  = 256,
    localparam int unsigned ID_W   = (AXIS_ID_WIDTH   > 0) ? AXIS_ID_WIDTH   : 1,
    localparam int unsigned DEST_W = (AXIS_DEST_WIDTH > 0) ? AXIS_DEST_WIDTH : 1,
    localparam int unsigned KEEP_W = AXIS_BUS_WIDTH / 8
) (
    input  logic                      aclk,
    input  logic                      areset,

    input  logic [AXIS_BUS_WIDTH-1:0] axis_in_tdata,
    input  logic [ID_W-1:0]           axis_in_tid,
    input  logic [DEST_W-1:0]         axis_in_tdest,
    input  logic [KEEP_W-1:0]         axis_in_tkeep,
    input  logic                      axis_in_tlast,
    input  logic                      axis_in_tvalid,
    output logic                      axis_in_tready,

    output logic [AXIS_BUS_WIDTH-1:0] axis_out_tdata,
    output logic [ID_W-1:0]           axis_out_tid,
    output logic [DEST_W-1:0]         axis_out_tdest,
    output logic [KEEP_W-1:0]         axis_out_tkeep,
    output logic                      axis_out_tlast,
    output logic                      axis_out_tvalid,
    input  logic                      axis_out_tready,

    input  logic                      force_end,
    output logic                      tlast_forced,
    output logic [2:0]                status_vector,
    output logic [15:0]               forced_count
);

    localparam int unsigned BEAT_W  = $clog2(MAX_PKT_BEATS);
    localparam int unsigned IDLE_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PKT,
        ST_INJECT,
        ST_DRAIN
    } state_t;

    state_t              state;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [ID_W-1:0]     id_q;
    logic [DEST_W-1:0]   dest_q;
    logic                sticky_ovf;
    logic                sticky_term;

    logic                at_max_c;
    logic                in_hs_c;
    logic                timeout_hit_c;
    logic                pkt_closes_c;

    assign at_max_c      = (beat_cnt == BEAT_W'(MAX_PKT_BEATS - 1));
    assign in_hs_c       = axis_in_tvalid && axis_in_tready;
    assign timeout_hit_c = (TIMEOUT_CYCLES != 0) && !axis_in_tvalid
                           && (idle_cnt == IDLE_W'(TO_LAST));
    // a beat that ends the packet this cycle wins over force_end and timeout
    assign pkt_closes_c  = in_hs_c && (axis_in_tlast || at_max_c);

    assign status_vector = {sticky_term, sticky_ovf, (state == ST_DRAIN)};

    // Output mux: pass-through, injected terminator, or drain; all gated by reset
    always_comb begin
        axis_in_tready  = 1'b0;
        axis_out_tvalid = 1'b0;
        axis_out_tdata  = axis_in_tdata;
        axis_out_tid    = axis_in_tid;
        axis_out_tdest  = axis_in_tdest;
        axis_out_tkeep  = axis_in_tkeep;
        axis_out_tlast  = 1'b0;
        tlast_forced    = 1'b0;
        if (!areset) begin
            case (state)
                ST_IDLE, ST_PKT: begin
                    axis_out_tvalid = axis_in_tvalid;
                    axis_in_tready  = axis_out_tready;
                    axis_out_tlast  = axis_in_tlast || at_max_c;
                    tlast_forced    = axis_in_tvalid && at_max_c && !axis_in_tlast;
                end
                ST_INJECT: begin
                    axis_out_tvalid = 1'b1;
                    axis_out_tlast  = 1'b1;
                    axis_out_tkeep  = '0;
                    axis_out_tdata  = '0;
                    axis_out_tid    = id_q;
                    axis_out_tdest  = dest_q;
                    tlast_forced    = 1'b1;
                end
                ST_DRAIN: begin
                    axis_in_tready  = 1'b1;
                end
                default: begin
                    axis_in_tready  = 1'b0;
                end
            endcase
        end
    end

    // Framing FSM with beat/idle counters, sticky status and forced-termination count
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state        <= ST_IDLE;
            beat_cnt     <= '0;
            idle_cnt     <= '0;
            id_q         <= '0;
            dest_q       <= '0;
            sticky_ovf   <= 1'b0;
            sticky_term  <= 1'b0;
            forced_count <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_PKT: begin
                    idle_cnt <= '0;
                    if (in_hs_c) begin
                        if (state == ST_IDLE) begin
                            id_q   <= axis_in_tid;
                            dest_q <= axis_in_tdest;
                        end
                        if (axis_in_tlast) begin
                            state    <= ST_IDLE;
                            beat_cnt <= '0;
                        end else if (at_max_c) begin
                            state      <= ST_DRAIN;
                            beat_cnt   <= '0;
                            sticky_ovf <= 1'b1;
                            if (forced_count != 16'hFFFF) begin
                                forced_count <= forced_count + 16'd1;
                            end
                        end else begin
                            state    <= ST_PKT;
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end
                    if ((state == ST_PKT) && !pkt_closes_c) begin
                        if (force_end || timeout_hit_c) begin
                            state <= ST_INJECT;
                        end else if (!axis_in_tvalid) begin
                            idle_cnt <= idle_cnt + IDLE_W'(1);
                        end
                    end
                end
                ST_INJECT: begin
                    if (axis_out_tready) begin
                        state       <= ST_DRAIN;
                        beat_cnt    <= '0;
                        sticky_term <= 1'b1;
                        if (forced_count != 16'hFFFF) begin
                            forced_count <= forced_count + 16'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (in_hs_c && axis_in_tlast) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_tx_protocol_corrector.sv
// Testbench for axis_tx_protocol_corrector: directed scenarios plus random
// packets, every cycle compared against a packet-level reference model.
module tb_axis_tx_protocol_corrector;

    localparam int unsigned BUS  = 32;
    localparam int unsigned KW   = BUS / 8;
    localparam int unsigned MAXB = 4;
    localparam int unsigned TO   = 8;

    logic            aclk = 1'b0;
    logic            areset;
    logic [BUS-1:0]  axis_in_tdata;
    logic [3:0]      axis_in_tid;
    logic [3:0]      axis_in_tdest;
    logic [KW-1:0]   axis_in_tkeep;
    logic            axis_in_tlast;
    logic            axis_in_tvalid;
    logic            axis_in_tready;
    logic [BUS-1:0]  axis_out_tdata;
    logic [3:0]      axis_out_tid;
    logic [3:0]      axis_out_tdest;
    logic [KW-1:0]   axis_out_tkeep;
    logic            axis_out_tlast;
    logic            axis_out_tvalid;
    logic            axis_out_tready;
    logic            force_end;
    logic            tlast_forced;
    logic [2:0]      status_vector;
    logic [15:0]     forced_count;

    axis_tx_protocol_corrector #(
        .AXIS_BUS_WIDTH (BUS),
        .AXIS_ID_WIDTH  (4),
        .AXIS_DEST_WIDTH(4),
        .MAX_PKT_BEATS  (MAXB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .aclk           (aclk),
        .areset         (areset),
        .axis_in_tdata  (axis_in_tdata),
        .axis_in_tid    (axis_in_tid),
        .axis_in_tdest  (axis_in_tdest),
        .axis_in_tkeep  (axis_in_tkeep),
        .axis_in_tlast  (axis_in_tlast),
        .axis_in_tvalid (axis_in_tvalid),
        .axis_in_tready (axis_in_tready),
        .axis_out_tdata (axis_out_tdata),
        .axis_out_tid   (axis_out_tid),
        .axis_out_tdest (axis_out_tdest),
        .axis_out_tkeep (axis_out_tkeep),
        .axis_out_tlast (axis_out_tlast),
        .axis_out_tvalid(axis_out_tvalid),
        .axis_out_tready(axis_out_tready),
        .force_end      (force_end),
        .tlast_forced   (tlast_forced),
        .status_vector  (status_vector),
        .forced_count   (forced_count)
    );

    always #5 aclk = ~aclk;

    int tests = 0;
    int fails = 0;
    int rdy_pct;
    int fe_pct;
    bit fe_hold;
    bit hs_seen;
    bit obs_ov;

    // reference model: packet-level view of the corrector
    int         m_n;        // beats forwarded in the open packet (0 = none open)
    bit         m_drop;     // discarding remainder of a cut packet
    bit         m_owe;      // terminator beat owed downstream
    int         m_quiet;    // consecutive input-idle cycles in an open packet
    int         m_forced;
    bit         m_ovf;
    bit         m_term;
    logic [3:0] m_id;
    logic [3:0] m_dest;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_drop = 0; m_owe = 0; m_quiet = 0;
        m_forced = 0; m_ovf = 0; m_term = 0; m_id = '0; m_dest = '0;
    endtask

    task automatic bump();
        if (m_forced < 65535) m_forced++;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_out_tvalid", 64'(axis_out_tvalid), 64'(0));
        chk("rst_in_tready", 64'(axis_in_tready), 64'(0));
        chk("rst_tlast_forced", 64'(tlast_forced), 64'(0));
        chk("rst_status", 64'(status_vector), 64'(0));
        chk("rst_forced_count", 64'(forced_count), 64'(0));
    endtask

    // one clock: compare outputs at negedge, advance model, return at posedge+1
    task automatic step();
        bit         v, l, ev, er, ef, was_open, closed;
        logic [63:0] eb;
        axis_out_tready = ($urandom_range(0, 99) < rdy_pct);
        force_end = fe_hold || ($urandom_range(0, 99) < fe_pct);
        @(negedge aclk);
        v = axis_in_tvalid;
        l = axis_in_tlast;
        if (m_owe) begin
            ev = 1; er = 0; ef = 1;
            eb = 64'({32'h0, 4'h0, 1'b1, m_id, m_dest});
        end else if (m_drop) begin
            ev = 0; er = 1; ef = 0; eb = '0;
        end else begin
            ev = v; er = axis_out_tready;
            ef = v && !l && (m_n == MAXB - 1);
            eb = 64'({axis_in_tdata, axis_in_tkeep, l || (m_n == MAXB - 1),
                      axis_in_tid, axis_in_tdest});
        end
        chk("out_tvalid", 64'(axis_out_tvalid), 64'(ev));
        chk("in_tready", 64'(axis_in_tready), 64'(er));
        chk("tlast_forced", 64'(tlast_forced), 64'(ef));
        if (ev) chk("out_beat", 64'({axis_out_tdata, axis_out_tkeep, axis_out_tlast,
                                     axis_out_tid, axis_out_tdest}), eb);
        chk("status", 64'(status_vector), 64'({m_term, m_ovf, m_drop}));
        chk("forced_count", 64'(forced_count), 64'(m_forced));
        obs_ov  = axis_out_tvalid;
        hs_seen = v && axis_in_tready;

        if (m_owe) begin
            if (axis_out_tready) begin
                m_owe = 0; m_drop = 1; m_term = 1; bump();
            end
        end else if (m_drop) begin
            if (v && l) m_drop = 0;
        end else begin
            was_open = (m_n > 0);
            closed = 0;
            if (v && er) begin
                if (m_n == 0) begin m_id = axis_in_tid; m_dest = axis_in_tdest; end
                if (l) begin
                    m_n = 0; closed = 1;
                end else if (m_n == MAXB - 1) begin
                    m_n = 0; closed = 1; m_drop = 1; m_ovf = 1; bump();
                end else begin
                    m_n++;
                end
            end
            if (was_open && !closed) begin
                if (force_end) begin
                    m_owe = 1; m_n = 0; m_quiet = 0;
                end else if (!v) begin
                    m_quiet++;
                    if (m_quiet == TO) begin m_owe = 1; m_n = 0; m_quiet = 0; end
                end else begin
                    m_quiet = 0;
                end
            end else begin
                m_quiet = 0;
            end
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic put_beat(input int idx, input int len, input logic [3:0] id, input logic [3:0] dest);
        axis_in_tvalid = 1'b1;
        axis_in_tdata  = $urandom;
        axis_in_tkeep  = KW'($urandom_range(1, 15));
        axis_in_tid    = id;
        axis_in_tdest  = dest;
        axis_in_tlast  = (idx == len - 1);
    endtask

    task automatic wait_hs();
        hs_seen = 0;
        for (int w = 0; w < 300 && !hs_seen; w++) step();
        chk("hs_wait", 64'(hs_seen), 64'(1));
        axis_in_tvalid = 1'b0;
    endtask

    task automatic xfer(input int idx, input int len, input logic [3:0] id, input logic [3:0] dest);
        put_beat(idx, len, id, dest);
        wait_hs();
    endtask

    task automatic gap(input int n);
        axis_in_tvalid = 1'b0;
        axis_in_tdata  = $urandom;
        axis_in_tlast  = 1'($urandom_range(0, 1));
        repeat (n) step();
    endtask

    task automatic send_pkt(input int len, input int maxgap);
        logic [3:0] id, dest;
        id   = 4'($urandom_range(0, 15));
        dest = 4'($urandom_range(0, 15));
        for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 9) == 0) gap(TO + 1);
            else gap($urandom_range(0, maxgap));
            xfer(i, len, id, dest);
        end
    endtask

    initial begin
        int n;
        areset = 1'b1;
        axis_in_tvalid = 1'b1; axis_in_tlast = 1'b0; axis_in_tdata = '0;
        axis_in_tkeep = '1; axis_in_tid = '0; axis_in_tdest = '0;
        axis_out_tready = 1'b1; force_end = 1'b0;
        fe_hold = 0; rdy_pct = 100; fe_pct = 0;
        model_reset();
        #12;
        chk_reset_outputs();
        @(posedge aclk); #2;
        areset = 1'b0;
        axis_in_tvalid = 1'b0;
        @(posedge aclk); #1;

        // exact-length packet passes untouched
        for (int i = 0; i < 4; i++) xfer(i, 4, 4'h3, 4'h5);
        chk("pkt4_count", 64'(forced_count), 64'(0));

        // oversize packet: beat 4 forced, 5..7 dropped
        for (int i = 0; i < 7; i++) xfer(i, 7, 4'h6, 4'h9);
        chk("ovf_count", 64'(forced_count), 64'(1));
        chk("ovf_sticky", 64'(status_vector[1]), 64'(1));

        // timeout after 2 beats
        xfer(0, 5, 4'hA, 4'hC);
        xfer(1, 5, 4'h1, 4'h2);
        axis_in_tvalid = 1'b0;
        n = 0;
        do begin
            step();
            if (!obs_ov) n++;
        end while (!obs_ov && n < 20);
        chk("to_idle_cycles", 64'(n), 64'(8));
        for (int i = 2; i < 5; i++) xfer(i, 5, 4'hA, 4'hC);
        chk("to_count", 64'(forced_count), 64'(2));
        chk("to_sticky", 64'(status_vector[2]), 64'(1));

        // force_end together with a tlast handshake: no terminator
        xfer(0, 3, 4'h2, 4'h4);
        xfer(1, 3, 4'h2, 4'h4);
        fe_hold = 1;
        xfer(2, 3, 4'h2, 4'h4);
        fe_hold = 0;
        gap(1);
        chk("fe_last_noinj", 64'(obs_ov), 64'(0));
        chk("fe_last_count", 64'(forced_count), 64'(2));

        // force_end mid-packet, terminator stalled 5 cycles
        xfer(0, 5, 4'h7, 4'hE);
        xfer(1, 5, 4'h7, 4'hE);
        axis_in_tvalid = 1'b0;
        rdy_pct = 0; fe_hold = 1;
        step();
        fe_hold = 0;
        step();
        chk("fe_inj_next", 64'(obs_ov), 64'(1));
        repeat (4) step();
        rdy_pct = 100;
        step();
        for (int i = 2; i < 5; i++) xfer(i, 5, 4'h7, 4'hE);
        chk("fe_count", 64'(forced_count), 64'(3));

        // oversize beat stalled 5 cycles
        for (int i = 0; i < 3; i++) xfer(i, 7, 4'hB, 4'h1);
        put_beat(3, 7, 4'hB, 4'h1);
        rdy_pct = 0;
        repeat (5) step();
        chk("stall_no_accept", 64'(hs_seen), 64'(0));
        rdy_pct = 100;
        wait_hs();
        for (int i = 4; i < 7; i++) xfer(i, 7, 4'hB, 4'h1);
        chk("stall_count", 64'(forced_count), 64'(4));

        // asynchronous reset mid-packet
        xfer(0, 6, 4'h5, 4'h5);
        xfer(1, 6, 4'h5, 4'h5);
        put_beat(2, 6, 4'h5, 4'h5);
        axis_out_tready = 1'b1;
        #2 areset = 1'b1;
        #1 chk_reset_outputs();
        model_reset();
        @(posedge aclk); #2;
        areset = 1'b0;
        axis_in_tvalid = 1'b0;
        for (int i = 0; i < 4; i++) xfer(i, 4, 4'h8, 4'h3);
        chk("post_rst_count", 64'(forced_count), 64'(0));

        // random traffic
        fe_pct = 2;
        for (int p = 0; p < 150; p++) begin
            rdy_pct = $urandom_range(40, 100);
            send_pkt($urandom_range(1, 7), 2);
        end
        fe_pct = 0; rdy_pct = 100;
        gap(TO + 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
